// File: rtl/pixel_write_slave.sv
// Pixel write responder: accepts 32-bit pixel writes with wait_request backpressure,
// queues in-range writes in a FIFO and drains them into the frame-buffer RAM port
// whenever scanout does not own the RAM. Tracks per-frame pixel count and error flags.
module pixel_write_slave #(
    parameter int unsigned DEPTH        = 8,
    parameter int unsigned MEM_AW       = 19,
    parameter int unsigned FRAME_PIXELS = 307200,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter int unsigned CNT_W        = 19
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       write_enable_i,
    input  logic [31:0]                write_address_i,
    input  logic [31:0]                write_data_i,
    output logic                       wait_request_o,
    input  logic                       mem_busy_i,
    output logic                       mem_we_o,
    output logic [MEM_AW-1:0]          mem_addr_o,
    output logic [31:0]                mem_wdata_o,
    input  logic                       frame_clear_i,
    output logic [CNT_W-1:0]           pixel_count_o,
    output logic                       frame_done_o,
    output logic                       oor_error_o,
    output logic [$clog2(DEPTH):0]     fifo_level_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = PW + 1;
    localparam int unsigned EW = MEM_AW + 32;
    localparam logic [CNT_W-1:0] CntMax = CNT_W'(FRAME_PIXELS);

    logic              init_q;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q, level_d;
    logic [EW-1:0]     fifo_mem_q [DEPTH];
    logic              mem_we_q;
    logic [MEM_AW-1:0] mem_addr_q;
    logic [31:0]       mem_wdata_q;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              done_q, done_d;
    logic              oor_q, oor_d;

    logic [31:0] offset;
    logic [29:0] word;
    logic        in_range;
    logic        accept, push, pop, oor_hit;

    // Address decode and handshake; wait_request depends on registers only.
    always_comb begin
        offset         = write_address_i - BASE_ADDR;
        word           = offset[31:2];
        in_range       = (write_address_i >= BASE_ADDR) && (write_address_i[1:0] == 2'b00) &&
                         ({2'b00, word} < FRAME_PIXELS);
        wait_request_o = ~init_q | (level_q == LW'(DEPTH));
        accept         = write_enable_i & ~wait_request_o;
        push           = accept & in_range;
        oor_hit        = accept & ~in_range;
        pop            = (level_q != '0) & ~mem_busy_i;
    end

    // FIFO pointer/level and frame-status next-state.
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        level_d  = level_q;
        if (push && !pop) level_d = level_q + LW'(1);
        if (!push && pop) level_d = level_q - LW'(1);

        count_d = count_q;
        done_d  = done_q;
        oor_d   = oor_q | oor_hit;
        if (frame_clear_i) begin
            // A RAM write in the clearing cycle is the first pixel of the new frame.
            count_d = mem_we_q ? CNT_W'(1) : '0;
            done_d  = 1'b0;
            oor_d   = oor_hit;
        end else if (mem_we_q && count_q != CntMax) begin
            count_d = count_q + CNT_W'(1);
            if (count_d == CntMax) done_d = 1'b1;
        end
    end

    // Control state, registered RAM port and status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            init_q      <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            count_q     <= '0;
            done_q      <= 1'b0;
            oor_q       <= 1'b0;
        end else begin
            init_q   <= 1'b1;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            mem_we_q <= pop;
            if (pop) begin
                mem_addr_q  <= fifo_mem_q[rd_ptr_q][EW-1:32];
                mem_wdata_q <= fifo_mem_q[rd_ptr_q][31:0];
            end
            count_q <= count_d;
            done_q  <= done_d;
            oor_q   <= oor_d;
        end
    end

    // FIFO storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push) fifo_mem_q[wr_ptr_q] <= {word[MEM_AW-1:0], write_data_i};
    end

    assign mem_we_o      = mem_we_q;
    assign mem_addr_o    = mem_addr_q;
    assign mem_wdata_o   = mem_wdata_q;
    assign pixel_count_o = count_q;
    assign frame_done_o  = done_q;
    assign oor_error_o   = oor_q;
    assign fifo_level_o  = level_q;

endmodule

// File: tb/tb_pixel_write_slave.sv
// Directed bench for pixel_write_slave (small frame, non-zero base address).
module tb_pixel_write_slave;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned MEM_AW = 19;
    localparam int unsigned FP = 16;
    localparam logic [31:0] BASE = 32'h0000_1000;
    localparam int unsigned CNT_W = 19;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic write_enable = 1'b0;
    logic [31:0] write_address = '0;
    logic [31:0] write_data = '0;
    logic wait_request;
    logic mem_busy = 1'b0;
    logic mem_we;
    logic [MEM_AW-1:0] mem_addr;
    logic [31:0] mem_wdata;
    logic frame_clear = 1'b0;
    logic [CNT_W-1:0] pixel_count;
    logic frame_done;
    logic oor_error;
    logic [$clog2(DEPTH):0] fifo_level;

    int n_vec = 0;
    int n_fail = 0;
    int cycle = 0;
    int cap_addr[$];
    int cap_data[$];
    int cap_cyc[$];

    pixel_write_slave #(
        .DEPTH(DEPTH), .MEM_AW(MEM_AW), .FRAME_PIXELS(FP), .BASE_ADDR(BASE), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .write_enable_i(write_enable), .write_address_i(write_address),
        .write_data_i(write_data), .wait_request_o(wait_request),
        .mem_busy_i(mem_busy), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .frame_clear_i(frame_clear),
        .pixel_count_o(pixel_count), .frame_done_o(frame_done),
        .oor_error_o(oor_error), .fifo_level_o(fifo_level)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Record every RAM write mid-cycle.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            cap_addr.push_back(int'(mem_addr));
            cap_data.push_back(int'(mem_wdata));
            cap_cyc.push_back(cycle);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input longint obs, input longint exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_caps();
        cap_addr.delete();
        cap_data.delete();
        cap_cyc.delete();
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        int waited;
        write_enable = 1'b1;
        write_address = a;
        write_data = d;
        waited = 0;
        while (wait_request !== 1'b0 && waited < 200) begin
            tick();
            waited++;
        end
        if (waited >= 200) check("write_accept_timeout", 1, 0);
        tick();
        write_enable = 1'b0;
    endtask

    task automatic pulse_clear();
        frame_clear = 1'b1;
        tick();
        frame_clear = 1'b0;
    endtask

    task automatic wait_caps(input int n);
        for (int i = 0; i < 100 && cap_addr.size() < n; i++) tick();
        repeat (4) tick();
        check("capture_count", cap_addr.size(), n);
    endtask

    initial begin
        // 1: reset state and release.
        repeat (3) tick();
        check("rst_wait_request", wait_request, 1);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_pixel_count", pixel_count, 0);
        check("rst_flags", {frame_done, oor_error}, 0);
        check("rst_fifo_level", fifo_level, 0);
        rst = 1'b0;
        #1;
        check("release_wait_still_1", wait_request, 1);
        tick();
        check("release_wait_0", wait_request, 0);

        // 2: single write, two-cycle latency.
        clear_caps();
        write_enable = 1'b1;
        write_address = BASE + 32'h10;
        write_data = 32'h00FF_00FF;
        tick();
        write_enable = 1'b0;
        check("lat_c1_mem_we", mem_we, 0);
        check("lat_c1_level", fifo_level, 1);
        tick();
        check("lat_c2_mem_we", mem_we, 1);
        check("lat_c2_addr", mem_addr, 4);
        check("lat_c2_data", mem_wdata, 32'h00FF_00FF);
        tick();
        check("lat_c3_mem_we", mem_we, 0);
        check("lat_count", pixel_count, 1);

        // 3: fill under mem_busy, backpressure, then ordered drain.
        pulse_clear();
        check("clear_count", pixel_count, 0);
        clear_caps();
        mem_busy = 1'b1;
        for (int k = 0; k < 8; k++) do_write(BASE + 32'(4 * k), 32'hA0 + 32'(k));
        write_enable = 1'b1;
        write_address = BASE + 32'd32;
        write_data = 32'hA8;
        #1;
        check("full_wait_request", wait_request, 1);
        check("full_level", fifo_level, 8);
        check("busy_no_we", cap_addr.size(), 0);
        mem_busy = 1'b0;
        do_write(BASE + 32'd32, 32'hA8);
        wait_caps(9);
        for (int k = 0; k < 9 && k < cap_addr.size(); k++) begin
            check($sformatf("drain_addr_%0d", k), cap_addr[k], k);
            check($sformatf("drain_data_%0d", k), cap_data[k], 32'hA0 + k);
            check($sformatf("drain_cyc_%0d", k), cap_cyc[k] - cap_cyc[0], k);
        end
        check("drain_count", pixel_count, 9);
        check("drain_level", fifo_level, 0);

        // 4: out-of-range and misaligned writes are dropped and flagged.
        pulse_clear();
        clear_caps();
        do_write(BASE + 32'(4 * FP), 32'h1);
        check("oor_top_flag", oor_error, 1);
        pulse_clear();
        check("oor_cleared", oor_error, 0);
        do_write(BASE + 32'h2, 32'h2);
        check("oor_misalign_flag", oor_error, 1);
        do_write(BASE - 32'h4, 32'h3);
        repeat (4) tick();
        check("oor_no_ram", cap_addr.size(), 0);
        check("oor_level", fifo_level, 0);
        check("oor_count", pixel_count, 0);
        do_write(BASE + 32'(4 * (FP - 1)), 32'h55);
        wait_caps(1);
        check("last_word_addr", cap_addr.size() > 0 ? cap_addr[0] : -1, FP - 1);
        pulse_clear();

        // 5: saturation and frame_done.
        clear_caps();
        for (int k = 0; k < 15; k++) do_write(BASE + 32'(4 * k), 32'(k));
        wait_caps(15);
        check("pre_sat_count", pixel_count, 15);
        check("pre_sat_done", frame_done, 0);
        do_write(BASE + 32'd60, 32'h15);
        wait_caps(16);
        check("sat_count", pixel_count, 16);
        check("sat_done", frame_done, 1);
        do_write(BASE, 32'h17);
        wait_caps(17);
        check("post_sat_count", pixel_count, 16);
        check("post_sat_data", cap_data.size() > 16 ? cap_data[16] : -1, 32'h17);
        pulse_clear();
        check("fc_count", pixel_count, 0);
        check("fc_done", frame_done, 0);

        // 6: reset mid-drain flushes the FIFO.
        clear_caps();
        mem_busy = 1'b1;
        for (int k = 0; k < 5; k++) do_write(BASE + 32'(4 * k), 32'hB0 + 32'(k));
        check("pre_rst_level", fifo_level, 5);
        mem_busy = 1'b0;
        tick();
        check("mid_drain_we", mem_we, 1);
        rst = 1'b1;
        #1;
        check("rst_mid_we", mem_we, 0);
        check("rst_mid_level", fifo_level, 0);
        check("rst_mid_wait", wait_request, 1);
        tick();
        rst = 1'b0;
        repeat (10) tick();
        check("rst_no_ram", cap_addr.size(), 0);
        check("rst_count", pixel_count, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
